// File: rtl/q_pulse_monitor.sv
// q_pulse_monitor: synchronises the AND-stage output q, strobes its edges,
// measures each high run in clk cycles and keeps valid/glitch statistics.
module q_pulse_monitor #(
  parameter int CNT_W     = 8,
  parameter int WID_W     = 8,
  parameter int MIN_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             q_in,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic [WID_W-1:0] cur_width,
  output logic [WID_W-1:0] max_width,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;
  localparam logic [WID_W-1:0] WID_ONE = WID_W'(1);
  localparam logic [WID_W-1:0] WID_MAX = {WID_W{1'b1}};
  localparam logic [WID_W-1:0] WID_PRE = WID_MAX - WID_ONE;
  localparam logic [WID_W-1:0] MIN_W   = WID_W'(MIN_WIDTH);

  logic s1;
  logic s2;
  logic rise_evt;
  logic fall_evt;
  logic hold;
  logic valid_pulse;
  logic width_inc;
  logic pulse_inc;
  logic glitch_inc;
  logic any_sat_hit;

  // Two-flop synchroniser: q_in may be asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= q_in;
      s2 <= s1;
    end
  end

  // Edge/hold decode and saturation-aware increment enables.
  always_comb begin
    rise_evt    = s1 & ~s2;
    fall_evt    = ~s1 & s2;
    hold        = s1 & s2;
    valid_pulse = (cur_width >= MIN_W);
    width_inc   = hold && (cur_width != WID_MAX);
    pulse_inc   = fall_evt && valid_pulse && (pulse_cnt != CNT_MAX);
    glitch_inc  = fall_evt && !valid_pulse && (glitch_cnt != CNT_MAX);
    any_sat_hit = (width_inc && (cur_width == WID_PRE))
               || (pulse_inc && (pulse_cnt == CNT_PRE))
               || (glitch_inc && (glitch_cnt == CNT_PRE));
  end

  // Registered single-cycle strobes; clr deliberately leaves these alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= rise_evt;
      fall <= fall_evt;
    end
  end

  // Run-length counter: restarts at 1 on a rise, holds the last width after a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_width <= '0;
    end else if (clr) begin
      cur_width <= '0;
    end else if (rise_evt) begin
      cur_width <= WID_ONE;
    end else if (width_inc) begin
      cur_width <= cur_width + WID_ONE;
    end
  end

  // Classify each finished run as a valid pulse or a glitch; clr discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt  <= '0;
      glitch_cnt <= '0;
      max_width  <= '0;
    end else if (clr) begin
      pulse_cnt  <= '0;
      glitch_cnt <= '0;
      max_width  <= '0;
    end else begin
      if (pulse_inc) begin
        pulse_cnt <= pulse_cnt + CNT_ONE;
      end
      if (glitch_inc) begin
        glitch_cnt <= glitch_cnt + CNT_ONE;
      end
      if (fall_evt && valid_pulse && (cur_width > max_width)) begin
        max_width <= cur_width;
      end
    end
  end

  // Sticky overflow: set when any counter or the width first reaches all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (any_sat_hit) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_q_pulse_monitor.sv
// tb_q_pulse_monitor: drives two monitor instances (default parameters and a
// narrow-counter variant) from one q stream and checks both against a
// run-length model computed from the sampled q history.
module tb_q_pulse_monitor;

  localparam int A_CNT_W = 8;
  localparam int A_WID_W = 8;
  localparam int A_MIN   = 2;
  localparam int B_CNT_W = 2;
  localparam int B_WID_W = 4;
  localparam int B_MIN   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  logic q_in  = 1'b0;
  logic a     = 1'b0;
  logic b     = 1'b0;

  logic               rise_a, fall_a, ovf_a;
  logic [A_CNT_W-1:0] pc_a, gc_a;
  logic [A_WID_W-1:0] cw_a, mw_a;
  logic               rise_b, fall_b, ovf_b;
  logic [B_CNT_W-1:0] pc_b, gc_b;
  logic [B_WID_W-1:0] cw_b, mw_b;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  q_pulse_monitor #(.CNT_W(A_CNT_W), .WID_W(A_WID_W), .MIN_WIDTH(A_MIN)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .q_in(q_in),
    .rise(rise_a), .fall(fall_a), .pulse_cnt(pc_a), .glitch_cnt(gc_a),
    .cur_width(cw_a), .max_width(mw_a), .overflow(ovf_a)
  );

  q_pulse_monitor #(.CNT_W(B_CNT_W), .WID_W(B_WID_W), .MIN_WIDTH(B_MIN)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .q_in(q_in),
    .rise(rise_b), .fall(fall_b), .pulse_cnt(pc_b), .glitch_cnt(gc_b),
    .cur_width(cw_b), .max_width(mw_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  // Reference model: q sample history plus unbounded integer statistics,
  // saturated only when presented.
  int samp[$];
  int m_width[2];
  int m_pc[2];
  int m_gc[2];
  int m_max[2];
  bit m_ovf[2];
  bit m_rise;
  bit m_fall;

  function automatic int cmax(int i);
    return (i == 0) ? (1 << A_CNT_W) - 1 : (1 << B_CNT_W) - 1;
  endfunction

  function automatic int wmax(int i);
    return (i == 0) ? (1 << A_WID_W) - 1 : (1 << B_WID_W) - 1;
  endfunction

  function automatic int minw(int i);
    return (i == 0) ? A_MIN : B_MIN;
  endfunction

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int last(int k);
    if (samp.size() >= k) return samp[samp.size() - k];
    return 0;
  endfunction

  task automatic modelStep(input int i, input int x1, input int x2, input bit c);
    int w;
    if (c) begin
      m_width[i] = 0; m_pc[i] = 0; m_gc[i] = 0; m_max[i] = 0; m_ovf[i] = 1'b0;
    end else begin
      if (x1 == 1 && x2 == 0) begin
        m_width[i] = 1;
      end else if (x1 == 1 && x2 == 1) begin
        m_width[i] = m_width[i] + 1;
        if (m_width[i] >= wmax(i)) m_ovf[i] = 1'b1;
      end
      if (x1 == 0 && x2 == 1) begin
        w = sat(m_width[i], wmax(i));
        if (w >= minw(i)) begin
          m_pc[i] = m_pc[i] + 1;
          if (m_pc[i] >= cmax(i)) m_ovf[i] = 1'b1;
          if (w > m_max[i]) m_max[i] = w;
        end else begin
          m_gc[i] = m_gc[i] + 1;
          if (m_gc[i] >= cmax(i)) m_ovf[i] = 1'b1;
        end
      end
    end
  endtask

  // Advance the model on every sampling edge; reset wipes the history.
  always @(posedge clk or negedge rst_n) begin
    int x1, x2;
    if (!rst_n) begin
      samp.delete();
      m_rise = 1'b0;
      m_fall = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_width[i] = 0; m_pc[i] = 0; m_gc[i] = 0; m_max[i] = 0; m_ovf[i] = 1'b0;
      end
    end else begin
      x1 = last(1);
      x2 = last(2);
      m_rise = (x1 == 1 && x2 == 0);
      m_fall = (x1 == 0 && x2 == 1);
      for (int i = 0; i < 2; i++) modelStep(i, x1, x2, clr);
      samp.push_back(int'(q_in));
      if (samp.size() > 4) void'(samp.pop_front());
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare both instances against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("rise_a", int'(rise_a), int'(m_rise));
      checkOutput("fall_a", int'(fall_a), int'(m_fall));
      checkOutput("pulse_cnt_a", int'(pc_a), sat(m_pc[0], cmax(0)));
      checkOutput("glitch_cnt_a", int'(gc_a), sat(m_gc[0], cmax(0)));
      checkOutput("cur_width_a", int'(cw_a), sat(m_width[0], wmax(0)));
      checkOutput("max_width_a", int'(mw_a), m_max[0]);
      checkOutput("overflow_a", int'(ovf_a), int'(m_ovf[0]));
      checkOutput("rise_b", int'(rise_b), int'(m_rise));
      checkOutput("fall_b", int'(fall_b), int'(m_fall));
      checkOutput("pulse_cnt_b", int'(pc_b), sat(m_pc[1], cmax(1)));
      checkOutput("glitch_cnt_b", int'(gc_b), sat(m_gc[1], cmax(1)));
      checkOutput("cur_width_b", int'(cw_b), sat(m_width[1], wmax(1)));
      checkOutput("max_width_b", int'(mw_b), m_max[1]);
      checkOutput("overflow_b", int'(ovf_b), int'(m_ovf[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit q, input bit c);
    q_in = q;
    clr  = c;
  endtask

  task automatic clearStats();
    applyStimulus(q_in, 1'b1);
    tick();
    clr = 1'b0;
  endtask

  task automatic pulse(input int width, input int gap);
    applyStimulus(1'b1, 1'b0);
    repeat (width) tick();
    applyStimulus(1'b0, 1'b0);
    repeat (gap) tick();
  endtask

  task automatic checkStatsA(input string tag, input int pc, input int gc, input int cw, input int mw);
    checkOutput({tag, "_pulse_cnt"}, int'(pc_a), pc);
    checkOutput({tag, "_glitch_cnt"}, int'(gc_a), gc);
    checkOutput({tag, "_cur_width"}, int'(cw_a), cw);
    checkOutput({tag, "_max_width"}, int'(mw_a), mw);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit [1:0] pat [9];
    int rise_n, fall_n, remaining;
    bit lvl;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    checkOutput("reset_cur_width", int'(cw_a), 0);
    checkOutput("reset_overflow", int'(ovf_a), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (3) tick();

    // Test 1: four sampled-high cycles, strobe timing and width
    $display("[TB] test 1: width-4 pulse");
    applyStimulus(1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("t1_rise_edgeN", int'(rise_a), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("t1_rise_edgeN1", int'(rise_a), 1);
    @(posedge clk); @(negedge clk);
    checkOutput("t1_rise_edgeN2", int'(rise_a), 0);
    @(posedge clk); #2;
    applyStimulus(1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("t1_fall_early", int'(fall_a), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("t1_fall", int'(fall_a), 1);
    checkStatsA("t1", 1, 0, 4, 4);
    tick();

    // Test 2: q produced by the AND stage from the a/b exercise pattern
    $display("[TB] test 2: AND-stage pattern");
    clearStats();
    pat = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    rise_n = 0;
    fall_n = 0;
    for (int k = 0; k < 9; k++) begin
      a = pat[k][1];
      b = pat[k][0];
      applyStimulus(a & b, 1'b0);
      repeat (2) begin
        @(posedge clk); @(negedge clk);
        rise_n += int'(rise_a);
        fall_n += int'(fall_a);
      end
    end
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      rise_n += int'(rise_a);
      fall_n += int'(fall_a);
    end
    checkOutput("t2_rise_count", rise_n, 2);
    checkOutput("t2_fall_count", fall_n, 2);
    checkStatsA("t2", 2, 0, 2, 2);
    tick();

    // Test 3: a pulse between edges is missed; a one-cycle pulse is a glitch
    $display("[TB] test 3: missed pulse and glitch");
    clearStats();
    @(posedge clk); #3 q_in = 1'b1; #3 q_in = 1'b0;
    repeat (4) tick();
    checkStatsA("t3_missed", 0, 0, 0, 0);
    pulse(1, 4);
    checkStatsA("t3", 0, 1, 1, 0);

    // Test 4: widths 3, 7, 5
    $display("[TB] test 4: pulse widths 3/7/5");
    clearStats();
    pulse(3, 4);
    pulse(7, 4);
    pulse(5, 4);
    checkStatsA("t4", 3, 0, 5, 7);

    // Test 5: narrow counters saturate, then clr recovers
    $display("[TB] test 5: saturation and clear");
    clearStats();
    repeat (4) pulse(4, 4);
    checkOutput("t5_pulse_cnt_b", int'(pc_b), 3);
    checkOutput("t5_overflow_b", int'(ovf_b), 1);
    clearStats();
    @(negedge clk);
    checkOutput("t5_clr_pulse_cnt_b", int'(pc_b), 0);
    checkOutput("t5_clr_overflow_b", int'(ovf_b), 0);
    checkOutput("t5_clr_max_width_b", int'(mw_b), 0);
    tick();

    // Test 6: asynchronous reset in the middle of a pulse
    $display("[TB] test 6: reset mid-pulse");
    applyStimulus(1'b1, 1'b0);
    repeat (4) tick();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_cur_width", int'(cw_a), 0);
    checkOutput("t6_async_pulse_cnt", int'(pc_a), 0);
    checkOutput("t6_async_overflow_b", int'(ovf_b), 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("t6_rise_e1", int'(rise_a), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("t6_rise_e2", int'(rise_a), 1);
    repeat (3) @(posedge clk);
    #2 applyStimulus(1'b0, 1'b0);
    repeat (3) tick();
    checkStatsA("t6", 1, 0, 5, 5);

    // Randomised runs with occasional clr, sub-cycle glitches and resets
    $display("[TB] random phase");
    lvl = 1'b0;
    remaining = 3;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (remaining == 0) begin
        lvl = ~lvl;
        remaining = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 22))
                                                : int'($urandom_range(1, 4));
      end
      remaining--;
      applyStimulus(lvl, $urandom_range(0, 59) == 0);
      if (!lvl && $urandom_range(0, 19) == 0) begin
        #1 q_in = 1'b1;
        #3 q_in = 1'b0;
      end
      if ($urandom_range(0, 249) == 0) begin
        #2 rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #3 rst_n = 1'b1;
      end
      tick();
    end
    applyStimulus(1'b0, 1'b0);
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_pulse_monitor.md
Name: q_pulse_monitor

Overview:
- Downstream consumer of the two-input AND stage output q.
- Synchronises q, produces single-cycle rise/fall strobes, measures each high pulse's width in clk cycles, and classifies pulses as valid or glitch against a minimum width.
- Keeps saturating valid/glitch counters and the maximum valid width seen, for checking AND-stage activity in the exercise benches.

Parameters:
- CNT_W, 8, width of pulse_cnt and glitch_cnt.
- WID_W, 8, width of cur_width and max_width.
- MIN_WIDTH, 2, minimum high run length in cycles for a valid pulse. Range 1..2^WID_W-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of counters and statistics.
- q_in  input  1  q from the AND stage; may be asynchronous to clk.
- rise  output  1  one-cycle strobe on a synchronised 0->1 transition.
- fall  output  1  one-cycle strobe on a synchronised 1->0 transition.
- pulse_cnt  output  CNT_W  count of valid pulses.
- glitch_cnt  output  CNT_W  count of pulses shorter than MIN_WIDTH.
- cur_width  output  WID_W  length of the current or most recent high run.
- max_width  output  WID_W  largest valid pulse width since reset/clr.
- overflow  output  1  sticky flag: a counter or width has saturated.

Behaviour:
- Reset (rst_n=0, asynchronous): s1, s2, rise, fall, pulse_cnt, glitch_cnt, cur_width, max_width and overflow all go to 0 immediately. Release takes effect on the next clk edge.
- Sync chain: s1 <= q_in; s2 <= s1.
- Event detection:
  - rise_evt = s1 & ~s2
  - fall_evt = ~s1 & s2
  - hold = s1 & s2
- Strobes are registered: rise <= rise_evt; fall <= fall_evt.
- Latency: q_in sampled high at edge N gives rise=1 for exactly the cycle after edge N+1. Fall behaves the same way.
- Run counter (cur_width):
  - On rise_evt: cur_width <= 1.
  - On hold: cur_width <= cur_width+1, saturating at 2^WID_W-1. Reaching saturation sets overflow.
  - Otherwise cur_width holds its value, so it shows the last pulse width until the next rise.
- On fall_evt, classify the finished run:
  - If cur_width >= MIN_WIDTH: pulse_cnt increments (saturating; reaching max sets overflow). If cur_width > max_width, max_width <= cur_width.
  - Otherwise glitch_cnt increments (saturating; reaching max sets overflow).
  - Counter updates are visible in the same cycle that fall asserts.
- Width is counted in clk cycles that s1 is high. A q_in pulse that spans no sampling edge is missed entirely: no strobe, no count.
- clr=1 zeroes pulse_cnt, glitch_cnt, max_width, cur_width and overflow on the next edge. s1, s2, rise and fall are unaffected.
- clr together with fall_evt: clr wins and the finishing pulse is discarded.
- clr during a high run: cur_width restarts at 0 and counts on, so the pulse is measured from the clr point.
- rst_n asserted mid-pulse: all state is zeroed. If q_in is still high after release, s2=0 lets a fresh rise be detected, and that pulse is measured from reset release.
- Saturated counters hold at all-ones. overflow stays set until rst_n or clr.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then q_in high for 4 sampled cycles then low -> rise one cycle, 2 edges after q_in first sampled high. Fall one cycle, 2 edges after low. cur_width=4, pulse_cnt=1, max_width=4, glitch_cnt=0.
2. Drive a/b through the AND stage in the exercise pattern (pairs 00,01,10,11,00,01,10,11,00, each held 2 clk cycles) -> two rise and two fall strobes. pulse_cnt=2, max_width=2, glitch_cnt=0.
3. q_in high for 1 sampled cycle (MIN_WIDTH=2) -> glitch_cnt=1, pulse_cnt unchanged, max_width unchanged, cur_width=1.
4. Pulses of width 3, then 7, then 5 -> pulse_cnt=3, max_width=7, cur_width=5 after the last fall.
5. With CNT_W=2, four valid pulses -> pulse_cnt sticks at 3 and overflow=1. Then pulse clr -> all counters 0 and overflow=0.
6. Assert rst_n=0 asynchronously mid-pulse with q_in held high, then release -> outputs 0 immediately. A rise is seen 2 edges after release, and a later fall reports the width from release.
